// File: rtl/spi_input_conditioner.sv
// Conditions the raw SPI pins: two-flop synchronizer, per-channel stability
// debounce, and registered single-cycle edge pulses for SCLK and CS.
module spi_input_conditioner #(
   parameter int WAIT_TIME = 3,
   parameter int CNT_WIDTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_raw,
   input  logic cs_raw,
   input  logic mosi_raw,
   output logic sclk_c,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_c,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi_c
);

   // Channel index: 0 = sclk, 1 = cs, 2 = mosi. CS idles high (deselected).
   localparam int                   NUM_CH    = 3;
   localparam int                   NUM_EDGE  = 2;
   localparam logic [NUM_CH-1:0]    RESET_VAL = 3'b010;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(WAIT_TIME - 1);

   logic [NUM_CH-1:0]    sync0;
   logic [NUM_CH-1:0]    sync1;
   logic [NUM_CH-1:0]    cond;
   logic [CNT_WIDTH-1:0] cnt [NUM_CH];
   logic [NUM_EDGE-1:0]  rise_q;
   logic [NUM_EDGE-1:0]  fall_q;

   // Any cycle where sync1 agrees with cond restarts the count, so a level
   // is only accepted after WAIT_TIME consecutive mismatching cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0  <= RESET_VAL;
         sync1  <= RESET_VAL;
         cond   <= RESET_VAL;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync0 <= {mosi_raw, cs_raw, sclk_raw};
         sync1 <= sync0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync1[i] == cond[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               cond[i] <= sync1[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
         end
         // Pulses fire on the same edge that commits the new level (mosi has none).
         for (int i = 0; i < NUM_EDGE; i++) begin
            rise_q[i] <= sync1[i] & ~cond[i] & (cnt[i] == CNT_MAX);
            fall_q[i] <= ~sync1[i] & cond[i] & (cnt[i] == CNT_MAX);
         end
      end
   end

   assign sclk_c    = cond[0];
   assign cs_c      = cond[1];
   assign mosi_c    = cond[2];
   assign sclk_rise = rise_q[0];
   assign sclk_fall = fall_q[0];
   assign cs_rise   = rise_q[1];
   assign cs_fall   = fall_q[1];

endmodule

// File: doc/spi_input_conditioner.md
# spi_input_conditioner

Front-end conditioning stage for the SPI slave path. Takes the three raw, asynchronous SPI pins (SCLK, CS, MOSI) and brings each into the system clock domain with a two-flop synchronizer. Each pin is then debounced with a per-channel stability counter. The block emits clean levels plus single-cycle edge pulses, which feed the slave FSM, the shift register, and the address latch directly downstream.

## Interface
- WAIT_TIME, default 3: consecutive stable cycles after synchronization required before a level change is accepted; legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, default 3: width of each channel's debounce counter.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- sclk_raw  input  1  raw SPI clock pin, asynchronous.
- cs_raw  input  1  raw chip-select pin, active-low, asynchronous.
- mosi_raw  input  1  raw master-out pin, asynchronous.
- sclk_c  output  1  conditioned SCLK level.
- sclk_rise  output  1  one-cycle pulse when sclk_c goes 0->1.
- sclk_fall  output  1  one-cycle pulse when sclk_c goes 1->0.
- cs_c  output  1  conditioned CS level; 1 = deselected.
- cs_fall  output  1  one-cycle pulse when cs_c goes 1->0 (transaction start).
- cs_rise  output  1  one-cycle pulse when cs_c goes 0->1 (transaction end).
- mosi_c  output  1  conditioned MOSI level.

## Operation
- Three identical channels (sclk, cs, mosi). Each channel holds sync0, sync1, cond, cnt[CNT_WIDTH-1:0], rise_q, and fall_q.
- Synchronizer: sync0 <= raw, then sync1 <= sync0, every cycle.
- Debounce, evaluated every cycle:
  - If sync1 == cond: cnt <= 0; cond unchanged.
  - Else if cnt == WAIT_TIME-1: cond <= sync1; cnt <= 0.
  - Else: cnt <= cnt+1.
- Edge pulses are registered and update on the same edge that updates cond:
  - rise_q <= (sync1 & ~cond) & (cnt == WAIT_TIME-1).
  - fall_q <= (~sync1 & cond) & (cnt == WAIT_TIME-1).
  - Otherwise both are 0.
- Outputs map directly: *_c = cond; rise/fall outputs = rise_q/fall_q. The mosi channel produces no edge outputs.
- Glitch rejection: any return of sync1 to cond before the count completes clears cnt. A pulse shorter than WAIT_TIME synchronized cycles never reaches the output.
- Channels are fully independent. Simultaneous changes on several pins are each processed on their own schedule, with no priority or interaction.
- Reset values:
  - cs channel: sync0, sync1, and cond reset to 1.
  - sclk and mosi channels: sync0, sync1, and cond reset to 0.
  - All counters and pulse registers reset to 0.
  - After reset, sclk_c=0, cs_c=1, mosi_c=0, and all pulses are 0. No spurious edge pulse on reset release.
- Reset asserted mid-count abandons the count immediately. Outputs take reset values asynchronously.

## Timing
- Raw change seen at edge N (sets sync0). sync1 updates at N+1. First mismatch count at N+2. cond updates at edge N+1+WAIT_TIME, and the edge pulse is high from that edge for exactly one cycle.
- WAIT_TIME=1 gives a total latency of 2 edges after sync0 capture. This is the minimum latency.
- Maximum toggle rate passed through: one level change per WAIT_TIME+1 clk cycles. SCLK must be held at least WAIT_TIME+2 clk cycles per phase for guaranteed capture.
- mosi_c lags raw MOSI by the same latency as sclk_c, so MOSI sampled at sclk_rise reflects data set up before the raw SCLK edge.
- Pulse outputs are never high on two consecutive cycles. rise and fall of one channel are never high together.

## Test plan
- Reset: hold rst_n=0 with all raw pins at 1, then release -> sclk_c=0 and mosi_c=0 until debounced; cs_c=1; no pulses for 5 cycles with pins stable.
- Clean edge, WAIT_TIME=3: sclk_raw 0->1 captured at edge N -> sclk_c=1 at edge N+4, sclk_rise=1 for exactly the cycle after N+4, sclk_fall stays 0.
- Glitch: cs_raw low for 2 clk cycles, then high -> cs_c stays 1, cs_fall never asserts, cnt returns to 0.
- Bounce: mosi_raw toggles 1,0,1,0 on successive cycles, then holds 1 -> mosi_c goes 1 exactly WAIT_TIME+1 edges after the final stable value reaches sync0, with a single transition.
- Full frame: cs_raw falls, then 8 SCLK periods of 10 clk per phase with MOSI 0xA5 -> one cs_fall, 8 sclk_rise and 8 sclk_fall pulses, mosi_c at each sclk_rise giving bits 1,0,1,0,0,1,0,1, one cs_rise at end.
- Mid-count reset: sclk_raw rises, rst_n pulled low two cycles later -> sclk_c=0 immediately, no sclk_rise; after release with sclk_raw still 1 -> normal debounce, one sclk_rise.
